fusion_cap_pool_pe: RTL

- Parametrised, fully pipelined pooling processing element for the CFNP fusion/capsule stage.
- Reduces N_IN signed fixed-point channels to one value per beat. Runtime modes: average, saturated sum, max, min.
- Accepts one input vector per cycle behind a valid/ready handshake with downstream backpressure.
- Sits between the fusion feature buffer and the regression head; replaces the fixed 10-input averaging element.

---
 rtl/fusion_cap_pkg.sv | 39 +++
 rtl/fusion_cap_tree_level.sv | 68 ++++++
 rtl/fusion_cap_pool_pe.sv | 103 ++++++++++
 3 files changed

// File: rtl/fusion_cap_pkg.sv
// Shared mode encoding and elaboration helpers for the fusion/capsule pooling element.
package fusion_cap_pkg;

  typedef enum logic [1:0] {
    MODE_AVG = 2'b00,
    MODE_SUM = 2'b01,
    MODE_MAX = 2'b10,
    MODE_MIN = 2'b11
  } mode_e;

  // Tree depth for n leaves, never below one level.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Number of elements alive after s pairing levels (odd leftovers pass through).
  function automatic int level_count(input int n, input int s);
    int c;
    c = n;
    for (int i = 0; i < s; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Clamp a sign-extended sw-bit value into the signed dw-bit range.
  function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] value,
                                                   input int sw, input int dw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sw <= dw) return value;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fusion_cap_tree_level.sv
// One registered level of the parallel sum tree and max/min tree; pairs elements 2j and 2j+1.
module fusion_cap_tree_level
  import fusion_cap_pkg::*;
#(
  parameter int N_EL = 10,
  parameter int W    = 16,
  parameter int DW   = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               in_valid,
  input  logic [1:0]                         in_mode,
  input  logic [N_EL*W-1:0]                  in_sum,
  input  logic [N_EL*DW-1:0]                 in_cmp,
  output logic                               out_valid,
  output logic [1:0]                         out_mode,
  output logic [((N_EL+1)/2)*(W+1)-1:0]      out_sum,
  output logic [((N_EL+1)/2)*DW-1:0]         out_cmp
);

  localparam int N_OUT = (N_EL + 1) / 2;

  logic [N_OUT*(W+1)-1:0] sum_nxt;
  logic [N_OUT*DW-1:0]    cmp_nxt;

  function automatic logic [W:0] sext(input logic [W-1:0] v);
    return {v[W-1], v};
  endfunction

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [1:0] mode);
    if (mode == MODE_MIN) return ($signed(a) < $signed(b)) ? a : b;
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sum_nxt = '0;
    cmp_nxt = '0;
    for (int j = 0; j < N_EL / 2; j++) begin
      sum_nxt[j*(W+1) +: W+1] = sext(in_sum[2*j*W +: W]) + sext(in_sum[(2*j+1)*W +: W]);
      cmp_nxt[j*DW +: DW]     = pick(in_cmp[2*j*DW +: DW], in_cmp[(2*j+1)*DW +: DW], in_mode);
    end
    // Odd leftover keeps its slot at the end of the level, widened by sign extension.
    if (N_EL % 2 == 1) begin
      sum_nxt[(N_OUT-1)*(W+1) +: W+1] = sext(in_sum[(N_EL-1)*W +: W]);
      cmp_nxt[(N_OUT-1)*DW +: DW]     = in_cmp[(N_EL-1)*DW +: DW];
    end
  end

  // NOTE: stage data is reset too, because a reset must leave no stale values anywhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= MODE_AVG;
      out_sum   <= '0;
      out_cmp   <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every level samples its predecessor's old value.
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_sum   <= sum_nxt;
      out_cmp   <= cmp_nxt;
    end
  end

endmodule

// File: rtl/fusion_cap_pool_pe.sv
// Pipelined N_IN-channel pooling element: avg / saturated sum / max / min, valid-ready on both sides.
module fusion_cap_pool_pe
  import fusion_cap_pkg::*;
#(
  parameter int N_IN = 10,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [N_IN*DW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_mode,
  output logic [DW-1:0]      out_data
);

  localparam int LVL = clog2_safe(N_IN);
  localparam int SW  = DW + LVL;

  logic en;

  // Whole pipeline advances together; a held output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [LVL:0]         v_bus;
  logic [1:0]           m_bus   [LVL+1];
  logic [N_IN*SW-1:0]   sum_bus [LVL+1];
  logic [N_IN*DW-1:0]   cmp_bus [LVL+1];

  assign v_bus[0]   = in_valid;
  assign m_bus[0]   = in_mode;
  assign sum_bus[0] = (N_IN*SW)'(in_data);
  assign cmp_bus[0] = in_data;

  for (genvar s = 0; s < LVL; s++) begin : g_lvl
    localparam int NI = level_count(N_IN, s);
    localparam int NO = level_count(N_IN, s + 1);
    localparam int W  = DW + s;

    logic [NO*(W+1)-1:0] so;
    logic [NO*DW-1:0]    co;

    fusion_cap_tree_level #(
      .N_EL (NI),
      .W    (W),
      .DW   (DW)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (v_bus[s]),
      .in_mode   (m_bus[s]),
      .in_sum    (sum_bus[s][NI*W-1:0]),
      .in_cmp    (cmp_bus[s][NI*DW-1:0]),
      .out_valid (v_bus[s+1]),
      .out_mode  (m_bus[s+1]),
      .out_sum   (so),
      .out_cmp   (co)
    );

    assign sum_bus[s+1] = (N_IN*SW)'(so);
    assign cmp_bus[s+1] = (N_IN*DW)'(co);
  end

  logic signed [SW-1:0] root_sum;
  logic        [DW-1:0] root_cmp;
  logic signed [SW-1:0] avg_full;
  logic signed [63:0]   sum_sat;
  logic        [DW-1:0] res_nxt;

  assign root_sum = $signed(sum_bus[LVL][SW-1:0]);
  assign root_cmp = cmp_bus[LVL][DW-1:0];

  // Signed division truncates toward zero; |sum| <= N_IN * 2^(DW-1) so the quotient fits DW.
  assign avg_full = root_sum / $signed(SW'(N_IN));
  assign sum_sat  = sat_to_dw(64'(root_sum), SW, DW);

  always_comb begin
    res_nxt = root_cmp;
    case (m_bus[LVL])
      MODE_AVG: res_nxt = avg_full[DW-1:0];
      MODE_SUM: res_nxt = sum_sat[DW-1:0];
      default:  res_nxt = root_cmp;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mode  <= MODE_AVG;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= v_bus[LVL];
      out_mode  <= m_bus[LVL];
      out_data  <= res_nxt;
    end
  end

endmodule
